// File: rtl/vic_reg_loader_if.sv
// Command/register-file bus for vic_reg_loader.
//   i_cmd_data/i_cmd_valid/o_cmd_ready : host byte stream (valid/ready)
//   o_VIC_regaddr/o_VIC_data/o_VIC_we  : register-file write port
//   i_VIC_data                         : register-file readback (comb. from o_VIC_regaddr)
//   o_rd_data/o_rd_valid/i_rd_ready    : captured readback to the host (valid/ready)
//   o_busy/o_err                       : status
// Modport slave is the loader; master is the surrounding host/register-file side.
interface vic_reg_loader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
);
    logic [7:0]        i_cmd_data;
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic [ADDR_W-1:0] o_VIC_regaddr;
    logic [DATA_W-1:0] o_VIC_data;
    logic              o_VIC_we;
    logic [DATA_W-1:0] i_VIC_data;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_rd_valid;
    logic              i_rd_ready;
    logic              o_busy;
    logic              o_err;

    modport slave (
        input  i_cmd_data, i_cmd_valid, i_VIC_data, i_rd_ready,
        output o_cmd_ready, o_VIC_regaddr, o_VIC_data, o_VIC_we,
               o_rd_data, o_rd_valid, o_busy, o_err
    );

    modport master (
        output i_cmd_data, i_cmd_valid, i_VIC_data, i_rd_ready,
        input  o_cmd_ready, o_VIC_regaddr, o_VIC_data, o_VIC_we,
               o_rd_data, o_rd_valid, o_busy, o_err
    );
endinterface

// File: rtl/vic_reg_loader.sv
// vic_reg_loader: decodes a host byte-command stream into timed writes
// (single / wrapping burst) and single-register readback on the VIC
// register-file port.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - vic_reg_loader_if.slave (command stream, write port, readback, status)
// Command byte: [7:5] opcode (000 NOP, 001 WRITE, 010 BURST, 011 READ), [4:0] address.
// Optional build macro VIC_LOADER_AUTO_ENABLE_EN: after a burst whose last
// address is not 31, one extra write of all-ones to register 31 is appended.
module vic_reg_loader #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 4,
    parameter int SETUP_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input logic             clk,
    input logic             rst,
    vic_reg_loader_if.slave bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GET_CNT  = 3'd1;
    localparam logic [2:0] S_GET_DATA = 3'd2;
    localparam logic [2:0] S_SETUP    = 3'd3;
    localparam logic [2:0] S_STROBE   = 3'd4;
    localparam logic [2:0] S_HOLD     = 3'd5;
    localparam logic [2:0] S_RD_WAIT  = 3'd6;
    localparam logic [2:0] S_RD_OUT   = 3'd7;

    localparam logic [1:0] SETUP_LD = 2'(SETUP_CYC - 1);
    localparam logic [1:0] HOLD_LD  = 2'(HOLD_CYC - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;        // address of the next burst/single write
    logic [ADDR_W-1:0] regaddr_q, regaddr_d;  // address presented to the register file
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [4:0]        cnt_q, cnt_d;          // remaining burst bytes minus one
    logic [1:0]        tmr_q, tmr_d;          // setup/hold cycle countdown
    logic              burst_q, burst_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q, err_d;
`ifdef VIC_LOADER_AUTO_ENABLE_EN
    logic              auto_q, auto_d;        // current write is the appended enable write
`endif

    logic       cmd_ready;
    logic       accept;
    logic [2:0] opcode;

    assign opcode = bus.i_cmd_data[7:5];
    // Gated by rst so every output reads 0 while reset is held.
    assign cmd_ready = rst && ((state_q == S_IDLE) || (state_q == S_GET_CNT) ||
                               (state_q == S_GET_DATA));
    assign accept = bus.i_cmd_valid && cmd_ready;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        regaddr_d  = regaddr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        tmr_d      = tmr_q;
        burst_d    = burst_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        err_d      = err_q;
`ifdef VIC_LOADER_AUTO_ENABLE_EN
        auto_d     = auto_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (opcode)
                        3'b000: err_d = 1'b0;
                        3'b001: begin
                            addr_d  = ADDR_W'(bus.i_cmd_data[4:0]);
                            burst_d = 1'b0;
                            state_d = S_GET_DATA;
                        end
                        3'b010: begin
                            addr_d  = ADDR_W'(bus.i_cmd_data[4:0]);
                            burst_d = 1'b1;
                            state_d = S_GET_CNT;
                        end
                        3'b011: begin
                            regaddr_d = ADDR_W'(bus.i_cmd_data[4:0]);
                            state_d   = S_RD_WAIT;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_GET_CNT: begin
                if (accept) begin
                    cnt_d   = bus.i_cmd_data[4:0];
                    state_d = S_GET_DATA;
                end
            end
            S_GET_DATA: begin
                if (accept) begin
                    regaddr_d = addr_q;
                    wdata_d   = DATA_W'(bus.i_cmd_data[3:0]);
                    tmr_d     = SETUP_LD;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (tmr_q == '0) state_d = S_STROBE;
                else             tmr_d   = tmr_q - 2'd1;
            end
            S_STROBE: begin
                tmr_d   = HOLD_LD;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - 2'd1;
`ifdef VIC_LOADER_AUTO_ENABLE_EN
                end else if (auto_q) begin
                    auto_d  = 1'b0;
                    state_d = S_IDLE;
`endif
                end else if (burst_q && (cnt_q != '0)) begin
                    cnt_d   = cnt_q - 5'd1;
                    addr_d  = addr_q + ADDR_W'(1);  // wraps 31 -> 0
                    state_d = S_GET_DATA;
`ifdef VIC_LOADER_AUTO_ENABLE_EN
                end else if (burst_q && (regaddr_q != '1)) begin
                    auto_d    = 1'b1;
                    regaddr_d = '1;
                    wdata_d   = '1;
                    tmr_d     = SETUP_LD;
                    state_d   = S_SETUP;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                rd_data_d  = bus.i_VIC_data;
                rd_valid_d = 1'b1;
                state_d    = S_RD_OUT;
            end
            S_RD_OUT: begin
                if (bus.i_rd_ready) begin
                    rd_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            regaddr_q  <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            tmr_q      <= '0;
            burst_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
`ifdef VIC_LOADER_AUTO_ENABLE_EN
            auto_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            regaddr_q  <= regaddr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            burst_q    <= burst_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
`ifdef VIC_LOADER_AUTO_ENABLE_EN
            auto_q     <= auto_d;
`endif
        end
    end

    assign bus.o_cmd_ready   = cmd_ready;
    assign bus.o_VIC_regaddr = regaddr_q;
    assign bus.o_VIC_data    = wdata_q;
    assign bus.o_VIC_we      = (state_q == S_STROBE);
    assign bus.o_rd_data     = rd_data_q;
    assign bus.o_rd_valid    = rd_valid_q;
    assign bus.o_busy        = (state_q != S_IDLE);
    assign bus.o_err         = err_q;
endmodule

// File: tb/tb_vic_reg_loader.sv
// Self-checking bench for vic_reg_loader: a behavioural register-file model
// (expected-write queue + expected register contents) is built from the
// command semantics; a monitor checks every write strobe against it.
module tb_vic_reg_loader;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vic_reg_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

    vic_reg_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETUP_CYC(1), .HOLD_CYC(1)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(ifc)
    );

    typedef struct packed {
        logic [4:0] a;
        logic [3:0] d;
    } wr_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_accept = 0;
    int unsigned n_sent   = 0;

    logic [3:0] rf     [32];  // register file seen by the DUT
    logic [3:0] exp_rf [32];  // model contents
    wr_t        exp_q  [$];   // writes the model expects, in order
    logic [7:0] tx_q   [$];   // bytes still to send

    assign ifc.i_VIC_data = rf[ifc.o_VIC_regaddr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_write(input logic [4:0] a, input logic [3:0] d);
        exp_q.push_back(wr_t'({a, d}));
    endfunction

    // Write-port monitor: strobe legality, setup/hold stability, scoreboard.
    logic [4:0] prev_a, stb_a;
    logic [3:0] prev_d, stb_d;
    logic       prev_we = 1'b0;
    logic       hold_pend = 1'b0;
    always @(negedge clk) begin : mon
        wr_t e;
        if (!rst_n) begin
            hold_pend = 1'b0;
            prev_we   = 1'b0;
        end else begin
            if (ifc.i_cmd_valid && ifc.o_cmd_ready) n_accept++;
            if (hold_pend) begin
                check_eq("hold_we", ifc.o_VIC_we, 1'b0);
                check_eq("hold_addr", ifc.o_VIC_regaddr, stb_a);
                check_eq("hold_data", ifc.o_VIC_data, stb_d);
                check_eq("hold_ready", ifc.o_cmd_ready, 1'b0);
                hold_pend = 1'b0;
            end
            if (ifc.o_VIC_we) begin
                check_eq("setup_we", prev_we, 1'b0);
                check_eq("setup_addr", prev_a, ifc.o_VIC_regaddr);
                check_eq("setup_data", prev_d, ifc.o_VIC_data);
                check_eq("strobe_ready", ifc.o_cmd_ready, 1'b0);
                check_eq("we_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("wr_addr", ifc.o_VIC_regaddr, e.a);
                    check_eq("wr_data", ifc.o_VIC_data, e.d);
                    exp_rf[e.a] = e.d;
                end
                rf[ifc.o_VIC_regaddr] = ifc.o_VIC_data;
                stb_a     = ifc.o_VIC_regaddr;
                stb_d     = ifc.o_VIC_data;
                hold_pend = 1'b1;
            end
            prev_a  = ifc.o_VIC_regaddr;
            prev_d  = ifc.o_VIC_data;
            prev_we = ifc.o_VIC_we;
        end
    end

    // Streams tx_q with i_cmd_valid held high until every byte is accepted.
    task automatic send_all();
        int unsigned guard;
        while (tx_q.size() != 0) begin
            ifc.i_cmd_data  = tx_q[0];
            ifc.i_cmd_valid = 1'b1;
            guard = 0;
            while (guard <= 500) begin
                @(negedge clk);
                if (ifc.o_cmd_ready) break;
                guard++;
            end
            if (guard > 500) begin
                check_eq("send_timeout", guard, 0);
                tx_q.delete();
            end else begin
                @(posedge clk); #1;
                void'(tx_q.pop_front());
                n_sent++;
            end
        end
        ifc.i_cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n = 0;
        while (ifc.o_busy && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq(tag, ifc.o_busy, 1'b0);
        check_eq({tag, "_writes_done"}, exp_q.size(), 0);
    endtask

    task automatic queue_write(input logic [4:0] a, input logic [7:0] b);
        tx_q.push_back({3'b001, a});
        tx_q.push_back(b);
        model_write(a, b[3:0]);
    endtask

    // kind 0: random data, 1: data 1,2,3..., 2: bytes that look like commands
    task automatic queue_burst(input logic [4:0] a, input logic [4:0] cnt, input int kind);
        logic [7:0] cmdlike [4];
        logic [7:0] b;
        cmdlike[0] = 8'h25; cmdlike[1] = 8'h41; cmdlike[2] = 8'hE3; cmdlike[3] = 8'h65;
        tx_q.push_back({3'b010, a});
        tx_q.push_back({3'($urandom), cnt});
        for (int i = 0; i <= int'(cnt); i++) begin
            if (kind == 0)      b = 8'($urandom);
            else if (kind == 1) b = 8'(i + 1);
            else                b = cmdlike[i % 4];
            tx_q.push_back(b);
            model_write(5'((int'(a) + i) % 32), b[3:0]);
        end
`ifdef VIC_LOADER_AUTO_ENABLE_EN
        if (5'((int'(a) + int'(cnt)) % 32) != 5'd31) model_write(5'd31, 4'hF);
`endif
    endtask

    task automatic do_read(input logic [4:0] a, input int unsigned stall);
        int unsigned n = 0;
        tx_q.push_back({3'b011, a});
        send_all();
        while (!ifc.o_rd_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("rd_latency", n, 1);
        for (int unsigned i = 0; i <= stall; i++) begin
            check_eq("rd_valid_held", ifc.o_rd_valid, 1'b1);
            check_eq("rd_data", ifc.o_rd_data, exp_rf[a]);
            @(posedge clk); #1;
        end
        ifc.i_rd_ready = 1'b1;
        @(posedge clk); #1;
        ifc.i_rd_ready = 1'b0;
        check_eq("rd_valid_clear", ifc.o_rd_valid, 1'b0);
        check_eq("rd_busy_clear", ifc.o_busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, ifc.o_cmd_ready, 1'b0);
        check_eq({tag, "_addr"}, ifc.o_VIC_regaddr, 0);
        check_eq({tag, "_data"}, ifc.o_VIC_data, 0);
        check_eq({tag, "_we"}, ifc.o_VIC_we, 1'b0);
        check_eq({tag, "_rdata"}, ifc.o_rd_data, 0);
        check_eq({tag, "_rvalid"}, ifc.o_rd_valid, 1'b0);
        check_eq({tag, "_busy"}, ifc.o_busy, 1'b0);
        check_eq({tag, "_err"}, ifc.o_err, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] a;
        logic [4:0] c;
        for (int i = 0; i < 32; i++) begin
            rf[i] = 4'h0;
            exp_rf[i] = 4'h0;
        end
        rst_n = 1'b0;
        ifc.i_cmd_data  = 8'h00;
        ifc.i_cmd_valid = 1'b0;
        ifc.i_rd_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write with exact cycle timing.
        queue_write(5'd5, 8'h0A);
        send_all();
        check_eq("w1_setup_busy", ifc.o_busy, 1'b1);
        check_eq("w1_setup_we", ifc.o_VIC_we, 1'b0);
        @(posedge clk); #1;
        check_eq("w1_strobe_we", ifc.o_VIC_we, 1'b1);
        @(posedge clk); #1;
        check_eq("w1_hold_busy", ifc.o_busy, 1'b1);
        @(posedge clk); #1;
        check_eq("w1_idle", ifc.o_busy, 1'b0);
        wait_idle("w1");

        do_read(5'd5, 5);

        // Wrapping burst 30,31,0,1.
        queue_burst(5'd30, 5'd3, 1);
        send_all();
        wait_idle("burst_wrap");
        do_read(5'd30, 0);
        do_read(5'd31, 0);
        do_read(5'd0, 0);
        do_read(5'd1, 0);

        // Bad command, then NOP.
        tx_q.push_back(8'hE3);
        send_all();
        @(posedge clk); #1;
        check_eq("err_set", ifc.o_err, 1'b1);
        check_eq("err_busy", ifc.o_busy, 1'b0);
        tx_q.push_back(8'h00);
        send_all();
        @(posedge clk); #1;
        check_eq("err_clear", ifc.o_err, 1'b0);

        // Continuous valid: command-like data bytes followed by a WRITE.
        a = 5'($urandom);
        queue_burst(a, 5'd5, 2);
        queue_write(5'($urandom), 8'($urandom));
        send_all();
        wait_idle("stream");
        check_eq("stream_accepts", n_accept, n_sent);
        check_eq("stream_no_err", ifc.o_err, 1'b0);

        // Full 32-register burst.
        queue_burst(5'($urandom), 5'h1F, 0);
        send_all();
        wait_idle("burst32");
        for (int i = 0; i < 4; i++) do_read(5'($urandom), 0);

        // Random mix.
        for (int it = 0; it < 20; it++) begin
            a = 5'($urandom);
            c = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0: queue_write(a, 8'($urandom));
                1: queue_burst(a, c, 0);
                default: ;
            endcase
            send_all();
            wait_idle("rand");
            do_read(5'($urandom), $urandom_range(0, 3));
        end
        check_eq("rand_accepts", n_accept, n_sent);

        // Reset during a burst's first strobe; sticky err must also clear.
        tx_q.push_back(8'hE5);
        send_all();
        tx_q.push_back({3'b010, 5'd10});
        tx_q.push_back(8'h03);
        tx_q.push_back(8'h07);
        send_all();
        @(posedge clk); #1;
        check_eq("rst_pre_we", ifc.o_VIC_we, 1'b1);
        check_eq("rst_pre_err", ifc.o_err, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("postrst_busy", ifc.o_busy, 1'b0);
        queue_write(5'd10, 8'h0C);
        send_all();
        wait_idle("postrst");
        do_read(5'd10, 1);
        do_read(5'd11, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
